// File: rtl/rx_sched_pkg.sv
// Shared types and default parameters for the receiver slot-buffer drain scheduler.
package rx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    HOLD  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int DEF_SLOTS    = 4;
  localparam int DEF_DATA_W   = 2;
  localparam int DEF_READ_LAT = 1;

endpackage

// File: rtl/rr_picker.sv
// Round-robin slot picker: rotate requests to start just after `last`, then take the lowest set bit.
module rr_picker #(
  parameter int SLOTS  = 4,
  parameter int ADDR_W = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0]  req,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] grant_idx,
  output logic              any
);

  logic [SLOTS-1:0]  rot;
  logic [ADDR_W-1:0] off;

  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < SLOTS; i++) begin
      rot[i] = req[last + ADDR_W'(i + 1)];
    end
    // Walk downwards so the lowest rotated index is the one left in `off`.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (rot[i]) off = ADDR_W'(i);
    end
    grant_idx = last + off + ADDR_W'(1);
    any       = |req;
  end

endmodule

// File: rtl/rx_drain_scheduler.sv
// Drains occupied receive slots round-robin: read, present on valid/ready, then pulse a flag clear.
module rx_drain_scheduler
  import rx_sched_pkg::*;
#(
  parameter int SLOTS    = DEF_SLOTS,
  parameter int ADDR_W   = $clog2(SLOTS),
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [SLOTS-1:0]  flag_res,
  output logic [ADDR_W-1:0] rx_addr,
  input  logic [DATA_W-1:0] rx_data,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_slot,
  output logic              busy
);

  localparam int LAT_W = 2;

  // Handshake: a word transfers on any rising edge where out_valid & out_ready;
  // out_valid/out_data/out_slot stay constant from assertion until that edge.

  state_t            state, next_state;
  logic [ADDR_W-1:0] last, last_d;
  logic [LAT_W-1:0]  lat_cnt, lat_d;
  logic [ADDR_W-1:0] rx_addr_d, clr_addr_d, out_slot_d, grant_idx;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d, clr_en_d, any;
  logic              read_done, take;

  rr_picker #(.SLOTS(SLOTS), .ADDR_W(ADDR_W)) u_picker (
    .req       (flag_res),
    .last      (last),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign read_done = (lat_cnt == LAT_W'(READ_LAT - 1));
  assign take      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable && any) next_state = READ;
      READ:    if (read_done)     next_state = HOLD;
      HOLD:    if (take)          next_state = CLEAR;
      CLEAR:                      next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  always_comb begin
    rx_addr_d   = rx_addr;
    lat_d       = lat_cnt;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_slot_d  = out_slot;
    clr_en_d    = 1'b0;
    clr_addr_d  = clr_addr;
    last_d      = last;
    case (state)
      IDLE: begin
        if (enable && any) begin
          rx_addr_d = grant_idx;
          lat_d     = '0;
        end
      end
      READ: begin
        lat_d = lat_cnt + LAT_W'(1);
        if (read_done) begin
          out_data_d  = rx_data;
          out_slot_d  = rx_addr;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (take) begin
          out_valid_d = 1'b0;
          clr_en_d    = 1'b1;
          clr_addr_d  = rx_addr;
          last_d      = rx_addr;
        end
      end
      default: ;
    endcase
  end

  // Aborting on reset leaves `last` back at SLOTS-1 and the flag untouched, so the slot is re-served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_addr   <= '0;
      lat_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_slot  <= '0;
      clr_en    <= 1'b0;
      clr_addr  <= '0;
      last      <= ADDR_W'(SLOTS - 1);
      busy      <= 1'b0;
    end else begin
      rx_addr   <= rx_addr_d;
      lat_cnt   <= lat_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_slot  <= out_slot_d;
      clr_en    <= clr_en_d;
      clr_addr  <= clr_addr_d;
      last      <= last_d;
      busy      <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_rx_drain_scheduler.sv
// Bench for rx_drain_scheduler: READ_LAT=1 instance driven by directed and random transfers, READ_LAT=3 instance for latency.
module tb_rx_drain_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] flags;
  logic [1:0] mem [4];
  logic [1:0] rx_addr1, clr_addr1, out_slot1, out_data1, rx_data1;
  logic       clr_en1, out_valid1, out_ready1, busy1;

  logic       enable3;
  logic [3:0] flags3;
  logic [1:0] rx_addr3, clr_addr3, out_slot3, out_data3, rx_data3;
  logic       clr_en3, out_valid3, out_ready3, busy3;

  int checks   = 0;
  int failures = 0;
  int last_m;

  assign rx_data1 = mem[rx_addr1];

  rx_drain_scheduler #(.SLOTS(4), .DATA_W(2), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .flag_res(flags),
    .rx_addr(rx_addr1), .rx_data(rx_data1), .clr_en(clr_en1), .clr_addr(clr_addr1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_slot(out_slot1), .busy(busy1)
  );

  rx_drain_scheduler #(.SLOTS(4), .DATA_W(2), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .enable(enable3), .flag_res(flags3),
    .rx_addr(rx_addr3), .rx_data(rx_data3), .clr_en(clr_en3), .clr_addr(clr_addr3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_slot(out_slot3), .busy(busy3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model: a pulsed clear empties that slot's flag; read data for the latency-3 port changes every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (clr_en1) flags[clr_addr1] = 1'b0;
    if (clr_en3) flags3[clr_addr3] = 1'b0;
    rx_data3 = 2'($urandom);
  endtask

  // Reference arbitration: first flagged slot after the last one served, wrapping.
  function automatic int pick(input logic [3:0] f, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (f[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  // One full transfer on the READ_LAT=1 instance, starting in an IDLE cycle with enable high.
  task automatic run_xfer(input bit drop_en, input int hold_cycles);
    int s;
    logic [1:0] d;
    s = pick(flags, last_m);
    d = mem[s];
    out_ready1 = 1'b0;
    check("idle_busy", busy1, 0);
    step();
    check("read_busy", busy1, 1);
    check("read_addr", rx_addr1, s);
    check("read_valid", out_valid1, 0);
    if (drop_en) enable = 1'b0;
    step();
    check("hold_valid", out_valid1, 1);
    check("hold_data", out_data1, d);
    check("hold_slot", out_slot1, s);
    check("hold_clr", clr_en1, 0);
    for (int k = 0; k < hold_cycles; k++) begin
      step();
      check("stall_valid", out_valid1, 1);
      check("stall_data", out_data1, d);
      check("stall_slot", out_slot1, s);
      check("stall_clr", clr_en1, 0);
    end
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check("clr_en", clr_en1, 1);
    check("clr_addr", clr_addr1, s);
    check("clr_valid", out_valid1, 0);
    check("clr_busy", busy1, 1);
    last_m = s;
    step();
    check("post_clr_en", clr_en1, 0);
    check("post_busy", busy1, 0);
  endtask

  initial begin
    logic [1:0] cap;
    rst = 1'b1; enable = 1'b1; flags = '0; out_ready1 = 1'b0;
    enable3 = 1'b1; flags3 = '0; out_ready3 = 1'b1; rx_data3 = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    step();
    step();
    check("rst_rx_addr", rx_addr1, 0);
    check("rst_clr_en", clr_en1, 0);
    check("rst_clr_addr", clr_addr1, 0);
    check("rst_valid", out_valid1, 0);
    check("rst_data", out_data1, 0);
    check("rst_slot", out_slot1, 0);
    check("rst_busy", busy1, 0);
    check("rst_valid3", out_valid3, 0);
    rst = 1'b0;
    last_m = 3;

    // Single slot 0, ready high
    flags = 4'b0001; mem[0] = 2'b10;
    run_xfer(0, 0);

    // Round-robin order from reset, then wrap back to slot 0
    rst = 1'b1; step(); rst = 1'b0; last_m = 3;
    mem[0] = 2'b01; mem[1] = 2'b11; mem[3] = 2'b10;
    flags = 4'b1011;
    run_xfer(0, 0);
    run_xfer(0, 0);
    run_xfer(0, 0);
    flags = 4'b0001;
    run_xfer(0, 0);

    // Backpressure for 5 cycles
    flags = 4'b0010; mem[1] = 2'b01;
    run_xfer(0, 5);

    // enable low blocks new work; dropping it mid-READ still completes the transfer
    enable = 1'b0; flags = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      check("en_low_busy", busy1, 0);
    end
    enable = 1'b1;
    run_xfer(1, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("en_drop_idle", busy1, 0);
    end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (flags != 4'b0000) run_xfer(0, 0);
    end

    // Reset while holding slot 2: no clear, slot re-served afterwards
    flags = 4'b0100; mem[2] = 2'b11;
    step();
    step();
    check("rh_valid", out_valid1, 1);
    check("rh_slot", out_slot1, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_m = 3;
    check("rh_valid_after", out_valid1, 0);
    check("rh_clr", clr_en1, 0);
    check("rh_busy", busy1, 0);
    check("rh_flag_kept", flags, 4'b0100);
    run_xfer(0, 0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) mem[i] = 2'($urandom);
      flags = flags | 4'($urandom);
      if (flags == 4'b0000) flags[$urandom_range(0, 3)] = 1'b1;
      run_xfer(0, $urandom_range(0, 3));
    end

    // READ_LAT=3: data captured from the third READ cycle
    flags3 = 4'b0001;
    step();
    check("l3_busy", busy3, 1);
    check("l3_addr", rx_addr3, 0);
    step();
    step();
    cap = rx_data3;
    check("l3_valid_early", out_valid3, 0);
    step();
    check("l3_valid", out_valid3, 1);
    check("l3_data", out_data3, cap);
    check("l3_slot", out_slot3, 0);
    step();
    check("l3_clr", clr_en3, 1);
    check("l3_clr_addr", clr_addr3, 0);
    step();
    check("l3_clr_off", clr_en3, 0);
    check("l3_idle", busy3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_drain_scheduler.md
# rx_drain_scheduler

Read-side controller for the photonic receiver's slot buffer. Watches the receiver's per-slot "data present" flags and picks one occupied slot at a time, round-robin. Drives the receiver's read address, captures the returned data, and presents it to the core on a valid/ready handshake. Once the word is taken, it issues a one-cycle clear so the receiver can accept a new packet into that slot.

## Interface
Parameters:
- SLOTS, 4, number of receive slots (power of two, ≥2)
- ADDR_W, $clog2(SLOTS), width of rx_addr / slot index
- DATA_W, 2, payload width per slot
- READ_LAT, 1, cycles from rx_addr change to valid rx_data (1..3)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  when low, no new slot is started; an in-flight transfer completes
- flag_res  in  SLOTS  bit i = 1: slot i holds unread data
- rx_addr  out  ADDR_W  read address to receiver
- rx_data  in  DATA_W  receiver read data for rx_addr
- clr_en  out  1  one-cycle pulse: clear flag of slot clr_addr
- clr_addr  out  ADDR_W  slot to clear
- out_valid  out  1  out_data/out_slot valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  DATA_W  captured payload
- out_slot  out  ADDR_W  slot the payload came from
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, READ, HOLD, CLEAR.
- IDLE: if enable & |flag_res, pick slot s (below), load rx_addr←s, lat_cnt←0, go to READ; otherwise stay.
- Selection: search starts at last+1 mod SLOTS and wraps; the first set flag wins. last resets to SLOTS-1, so slot 0 has priority after reset.
- READ: rx_addr held at s; lat_cnt increments each cycle. In the cycle lat_cnt==READ_LAT-1: out_data←rx_data, out_slot←s, out_valid←1, go to HOLD.
- HOLD: out_valid, out_data and out_slot are stable until handshake. On out_valid & out_ready: out_valid←0, clr_en←1, clr_addr←s, last←s, go to CLEAR.
- CLEAR: clr_en is high for exactly this cycle; then return to IDLE with clr_en←0.
- flag_res is sampled only in IDLE. A flag dropping during READ/HOLD does not abort the transfer. A flag for slot s is ignored in CLEAR, because the receiver updates on that edge.
- enable low in READ/HOLD/CLEAR has no effect on the current transfer.
- No back-to-back pipelining: one slot in flight at a time.

## Timing
- Reset values: state IDLE, rx_addr 0, clr_en 0, clr_addr 0, out_valid 0, out_data 0, out_slot 0, busy 0, last SLOTS-1, lat_cnt 0.
- Reset in any state returns to IDLE on that edge. No clear is issued and the slot stays flagged, so it is re-served later.
- Latency: flag sampled in IDLE at cycle 0, then READ cycles 1..READ_LAT, then out_valid high from cycle READ_LAT+1.
- With out_ready tied high: handshake at cycle READ_LAT+1, clr_en at READ_LAT+2, IDLE at READ_LAT+3.
- Minimum service period per slot: READ_LAT+3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package rx_sched_pkg: state enum (IDLE, READ, HOLD, CLEAR) and a default-parameter constant set shared with the receiver testbench.
- Sub-module rr_picker: combinational, with inputs req[SLOTS] and last[ADDR_W], outputs grant_idx[ADDR_W] and any. It rotates the request vector and applies a priority encoder. It is the only combinational block.

## Test plan
- Reset then flag_res=4'b0001, out_ready=1, READ_LAT=1, rx_data=2'b10 for addr 0: out_valid at cycle 2 with out_data=2'b10, out_slot=0; clr_en=1, clr_addr=0 at cycle 3; busy low at cycle 4.
- flag_res=4'b1011 held (flags cleared by clr_en): service order 0, 1, 3. Then set 4'b0001 again: slot 0 is served, wrap-around verified.
- out_ready low for 5 cycles in HOLD: out_valid and out_data stable, clr_en stays 0. Raise out_ready: clr_en one cycle later, single pulse.
- enable=0 with flag_res=4'b1111: busy stays 0. Drop enable mid-READ: the transfer completes and the FSM stays in IDLE afterwards.
- Assert rst during HOLD for slot 2: out_valid=0 and clr_en never pulses. Next, with flag_res=4'b0100, slot 2 is re-served.
- READ_LAT=3, rx_data changes each cycle: out_data equals the value on rx_data in the third READ cycle.
